// File: rtl/hermes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hermes_pkg
//  Description : Shared types for the Hermes NoC glue logic: router port
//                enumeration, flit type, XY address helpers and the
//                packetizer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package hermes_pkg;

    localparam int c_FLIT_WIDTH = 32;
    localparam int c_COORD_W    = c_FLIT_WIDTH / 4;

    typedef logic [c_FLIT_WIDTH-1:0] flit_t;

    // Router port numbering
    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } e_port;

    // Packetizer FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_DROP    = 3'd2,
        ST_HEADER  = 3'd3,
        ST_SIZE    = 3'd4,
        ST_PAYLOAD = 3'd5
    } pkt_state_e;

    // X coordinate lives in the upper half of an address
    function automatic logic [c_COORD_W-1:0] addr_x(input logic [2*c_COORD_W-1:0] addr);
        return addr[2*c_COORD_W-1:c_COORD_W];
    endfunction

    // Y coordinate lives in the lower half of an address
    function automatic logic [c_COORD_W-1:0] addr_y(input logic [2*c_COORD_W-1:0] addr);
        return addr[c_COORD_W-1:0];
    endfunction

    // Build an address from its coordinates
    function automatic logic [2*c_COORD_W-1:0] pack_xy(input logic [c_COORD_W-1:0] x,
                                                       input logic [c_COORD_W-1:0] y);
        return {x, y};
    endfunction

endpackage
`default_nettype wire

// File: rtl/packetizer_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : packetizer_buffer
//  Description : Payload store for the packetizer. One write port, one
//                asynchronous read port; contents are not reset because the
//                FSM never reads a slot it has not written for this packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module packetizer_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [FLIT_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [FLIT_WIDTH-1:0] o_rd_data
);

    logic [FLIT_WIDTH-1:0] r_mem [DEPTH];

    // Write one flit per cycle when enabled
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Out-of-range addresses (non power-of-two depth) read as zero
    assign o_rd_data = (int'(i_rd_addr) < DEPTH) ? r_mem[i_rd_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/hermes_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : hermes_packetizer
//  Description : Store-and-forward packetizer feeding a Hermes router LOCAL
//                port. Buffers one payload, then emits header (XY target),
//                size and payload flits under credit flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module hermes_packetizer
    import hermes_pkg::*;
#(
    parameter int FLIT_WIDTH  = 32,
    parameter int MAX_PAYLOAD = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [FLIT_WIDTH-1:0]   s_data,
    input  logic                    s_last,
    input  logic [FLIT_WIDTH/2-1:0] s_dest,
    output logic                    tx,
    output logic [FLIT_WIDTH-1:0]   data_o,
    input  logic                    credit_i,
    output logic                    clock_tx,
    output logic                    busy,
    output logic                    pkt_sent,
    output logic                    overflow
);

    localparam int c_CNT_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int c_RD_W   = $clog2(MAX_PAYLOAD);
    localparam int c_DEST_W = FLIT_WIDTH / 2;

    pkt_state_e              r_state, w_state_next;
    logic [c_CNT_W-1:0]      r_count, w_count_next;
    logic [c_RD_W-1:0]       r_rd, w_rd_next;
    logic [c_DEST_W-1:0]     r_dest, w_dest_next;
    logic                    r_tx, w_tx_next;
    logic [FLIT_WIDTH-1:0]   r_data, w_data_next;
    logic                    w_accept, w_xfer, w_last_rd;
    logic                    w_wr_en, w_overflow, w_pkt_sent;
    logic [c_RD_W-1:0]       w_wr_addr;
    logic [FLIT_WIDTH-1:0]   w_rd_data;

    assign s_ready   = !reset && (r_state == ST_IDLE || r_state == ST_FILL || r_state == ST_DROP);
    assign w_accept  = s_valid && s_ready;
    assign w_xfer    = r_tx && credit_i;
    assign w_last_rd = (c_CNT_W'(r_rd) == r_count - c_CNT_W'(1));

    packetizer_buffer #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .DEPTH      (MAX_PAYLOAD),
        .ADDR_W     (c_RD_W)
    ) u_buffer (
        .clk       (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (s_data),
        .i_rd_addr (w_rd_next),
        .o_rd_data (w_rd_data)
    );

    // Next-state, counter and buffer-write decisions
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_rd_next    = r_rd;
        w_dest_next  = r_dest;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_count[c_RD_W-1:0];
        w_overflow   = 1'b0;
        w_pkt_sent   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = '0;
                    w_dest_next  = s_dest;
                    w_count_next = c_CNT_W'(1);
                    w_state_next = s_last ? ST_HEADER : ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    w_wr_en      = 1'b1;
                    w_count_next = r_count + c_CNT_W'(1);
                    if (s_last) begin
                        w_state_next = ST_HEADER;
                    end else if (w_count_next == c_CNT_W'(MAX_PAYLOAD)) begin
                        w_overflow   = 1'b1;
                        w_state_next = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (w_accept && s_last) begin
                    w_state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (w_xfer) begin
                    w_state_next = ST_SIZE;
                end
            end
            ST_SIZE: begin
                if (w_xfer) begin
                    w_rd_next    = '0;
                    w_state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_xfer) begin
                    w_rd_next = r_rd + c_RD_W'(1);
                    if (w_last_rd) begin
                        w_pkt_sent   = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs are computed for the state being entered, so the
    // header appears in the cycle right after the final accept
    always_comb begin
        w_tx_next   = 1'b0;
        w_data_next = '0;
        case (w_state_next)
            ST_HEADER: begin
                w_tx_next   = 1'b1;
                w_data_next = FLIT_WIDTH'(w_dest_next);
            end
            ST_SIZE: begin
                w_tx_next   = 1'b1;
                w_data_next = FLIT_WIDTH'(w_count_next);
            end
            ST_PAYLOAD: begin
                w_tx_next   = 1'b1;
                w_data_next = w_rd_data;
            end
            default: begin
                w_tx_next   = 1'b0;
                w_data_next = '0;
            end
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_rd    <= '0;
            r_dest  <= '0;
            r_tx    <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_rd    <= w_rd_next;
            r_dest  <= w_dest_next;
            r_tx    <= w_tx_next;
            r_data  <= w_data_next;
        end
    end

    assign tx       = r_tx;
    assign data_o   = r_data;
    assign clock_tx = clock;
    assign busy     = (r_state != ST_IDLE);
    assign pkt_sent = w_pkt_sent && !reset;
    assign overflow = w_overflow;

endmodule
`default_nettype wire

// File: tb/tb_hermes_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hermes_packetizer
//  Description : Self-checking bench for hermes_packetizer: queue-based
//                packet model compared every cycle, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hermes_packetizer;
    import hermes_pkg::*;

    localparam int c_MAXP = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [15:0] s_dest = '0;
    logic        tx;
    logic [31:0] data_o;
    logic        credit_i = 1'b1;
    logic        clock_tx;
    logic        busy;
    logic        pkt_sent;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    hermes_packetizer #(.FLIT_WIDTH(32), .MAX_PAYLOAD(c_MAXP)) dut (
        .clock    (clock),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_dest   (s_dest),
        .tx       (tx),
        .data_o   (data_o),
        .credit_i (credit_i),
        .clock_tx (clock_tx),
        .busy     (busy),
        .pkt_sent (pkt_sent),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model state ----------------
    logic [31:0] q[$];        // flits still to leave toward the router
    logic [31:0] pkt[$];      // payload being collected
    logic [15:0] dest_first;
    int          acc_n = 0;   // flits accepted for the current packet
    int          cyc = 0;
    bit          prev_rst = 1'b0;
    // logs for literal checks
    logic [31:0] log_data[$];
    int          log_cyc[$];
    int          sent_cyc[$];
    int          acc_cyc[$];
    int          first_acc[$];
    int          last_acc_cyc = 0;
    int          ovf_cyc[$];

    // Per-cycle comparison against the model; inputs and outputs are
    // stable at the falling edge, events take effect at the next rising edge
    always @(negedge clock) begin
        bit          exp_ready, exp_tx, xfer, accept, exp_ovf;
        cyc++;
        if (reset) begin
            chk("s_ready_in_reset", s_ready, 1'b0);
            if (prev_rst) begin
                chk("tx_in_reset", tx, 1'b0);
                chk("busy_in_reset", busy, 1'b0);
                chk("pkt_sent_in_reset", pkt_sent, 1'b0);
                chk("overflow_in_reset", overflow, 1'b0);
            end
            q.delete();
            pkt.delete();
            acc_n    = 0;
            prev_rst = 1'b1;
        end else begin
            prev_rst  = 1'b0;
            exp_ready = (q.size() == 0);
            exp_tx    = (q.size() != 0);
            chk("s_ready", s_ready, exp_ready);
            chk("tx", tx, exp_tx);
            chk("busy", busy, (acc_n != 0) || (q.size() != 0));
            if (exp_tx) chk("data_o", data_o, q[0]);
            xfer = exp_tx && credit_i;
            chk("pkt_sent", pkt_sent, xfer && (q.size() == 1));
            if (pkt_sent) sent_cyc.push_back(cyc);
            if (overflow) ovf_cyc.push_back(cyc);
            if (xfer) begin
                log_data.push_back(data_o);
                log_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            accept  = s_valid && exp_ready;
            exp_ovf = 1'b0;
            if (accept) begin
                if (acc_n == 0) begin
                    dest_first = s_dest;
                    first_acc.push_back(cyc);
                end
                acc_cyc.push_back(cyc);
                acc_n++;
                if (acc_n <= c_MAXP) pkt.push_back(s_data);
                exp_ovf = (acc_n == c_MAXP) && !s_last;
                if (s_last) begin
                    q.push_back({16'h0, dest_first});
                    q.push_back(32'(pkt.size()));
                    foreach (pkt[i]) q.push_back(pkt[i]);
                    pkt.delete();
                    acc_n        = 0;
                    last_acc_cyc = cyc;
                end
            end
            chk("overflow", overflow, exp_ovf);
        end
    end

    // ---------------- credit driver ----------------
    int cred_mode = 0;   // 0: always 1, 1: random, 2: pattern 1,0,0,1
    int cred_idx  = 0;
    always @(posedge clock) begin
        #1;
        case (cred_mode)
            1: credit_i = ($urandom_range(0, 2) != 0);
            2: begin
                credit_i = (cred_idx % 4 == 0) || (cred_idx % 4 == 3);
                cred_idx++;
            end
            default: credit_i = 1'b1;
        endcase
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_pkt(input int n, input logic [15:0] dest, input logic [31:0] base,
                            input int gap_max);
        bit got;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + 32'(i);
            s_last  = (i == n - 1);
            s_dest  = (i == 0) ? dest : 16'($urandom);
            got = 1'b0;
            for (int k = 0; k < 500; k++) begin
                @(negedge clock);
                got = s_ready;
                @(posedge clock);
                #1;
                if (got) break;
            end
            if (!got) chk("accept_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (q.size() == 0 && acc_n == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_cyc.delete();
        sent_cyc.delete();
        acc_cyc.delete();
        first_acc.delete();
        ovf_cyc.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] d0101;
        d0101 = pack_xy(8'h01, 8'h01);

        // reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_tx", tx, 1'b0);
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s_ready", s_ready, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_release", s_ready, 1'b1);
        @(posedge clock);
        #1;

        // 3-flit packet, credit always 1
        clear_logs();
        send_pkt(3, d0101, 32'hA0, 0);
        wait_done();
        chk("t1_nxfer", log_data.size(), 5);
        if (log_data.size() == 5) begin
            chk("t1_hdr", log_data[0], 32'h0000_0101);
            chk("t1_size", log_data[1], 32'd3);
            chk("t1_A", log_data[2], 32'hA0);
            chk("t1_B", log_data[3], 32'hA1);
            chk("t1_C", log_data[4], 32'hA2);
            chk("t1_hdr_latency", log_cyc[0], last_acc_cyc + 1);
            chk("t1_back_to_back", log_cyc[4], log_cyc[0] + 4);
            if (sent_cyc.size() == 1) chk("t1_sent_on_C", sent_cyc[0], log_cyc[4]);
            else chk("t1_sent_count", sent_cyc.size(), 1);
        end

        // same packet with credit 1,0,0,1
        clear_logs();
        cred_mode = 2;
        send_pkt(3, d0101, 32'hA0, 0);
        wait_done();
        cred_mode = 0;
        chk("t2_nxfer", log_data.size(), 5);
        if (log_data.size() == 5) begin
            chk("t2_hdr", log_data[0], 32'h0000_0101);
            chk("t2_size", log_data[1], 32'd3);
            chk("t2_C", log_data[4], 32'hA2);
        end

        // 18-flit packet: truncation to 16
        clear_logs();
        send_pkt(18, 16'h0203, 32'hB00, 0);
        wait_done();
        chk("t3_nxfer", log_data.size(), 18);
        if (log_data.size() == 18) begin
            chk("t3_size", log_data[1], 32'd16);
            chk("t3_last_payload", log_data[17], 32'hB0F);
        end
        chk("t3_novf", ovf_cyc.size(), 1);
        if (ovf_cyc.size() == 1 && acc_cyc.size() == 18)
            chk("t3_ovf_on_16th", ovf_cyc[0], acc_cyc[15]);

        // 1-flit packet
        clear_logs();
        send_pkt(1, 16'h0405, 32'hC0, 0);
        wait_done();
        chk("t4_nxfer", log_data.size(), 3);
        if (log_data.size() == 3) begin
            chk("t4_hdr", log_data[0], 32'h0000_0405);
            chk("t4_size", log_data[1], 32'd1);
            chk("t4_payload", log_data[2], 32'hC0);
        end

        // back-to-back 2-flit packets
        clear_logs();
        send_pkt(2, 16'h0101, 32'hD0, 0);
        send_pkt(2, 16'h0202, 32'hE0, 0);
        wait_done();
        chk("t5_npkts", first_acc.size(), 2);
        if (first_acc.size() == 2 && sent_cyc.size() >= 1)
            chk("t5_second_accept", first_acc[1], sent_cyc[0] + 1);

        // reset during PAYLOAD, then a fresh packet
        send_pkt(6, 16'h0303, 32'hF0, 0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t6_tx_after_rst", tx, 1'b0);
        chk("t6_busy_after_rst", busy, 1'b0);
        @(posedge clock);
        #1;
        clear_logs();
        send_pkt(2, 16'h0606, 32'h60, 0);
        wait_done();
        chk("t6_nxfer", log_data.size(), 4);
        if (log_data.size() == 4) begin
            chk("t6_hdr", log_data[0], 32'h0000_0606);
            chk("t6_p1", log_data[3], 32'h61);
        end

        // randomized traffic
        cred_mode = 1;
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 20), 16'($urandom), $urandom, 2);
            if ($urandom_range(0, 3) == 0) wait_done();
        end
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hermes_packetizer.md
# hermes_packetizer

Store-and-forward packetizer between a PE-side flit source and the LOCAL input port of a Hermes router in the manycore mesh. It buffers one payload of up to `MAX_PAYLOAD` flits and prepends a header flit (target XY address) and a size flit. It then streams header, size and payload into the router using Hermes credit flow control (`tx`/`credit_i`). One instance sits in each `manycore_pe`, driving the router's `LOCAL` `rx`/`data_i`/`clock_rx` inputs.

## Interface
- `FLIT_WIDTH`, 32, flit and data width; must be a multiple of 4.
- `MAX_PAYLOAD`, 16, payload buffer depth in flits; must be at least 2.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  PE-side flit valid.
- `s_ready`  out  1  PE-side flit accept.
- `s_data`  in  FLIT_WIDTH  payload flit.
- `s_last`  in  1  marks the final payload flit of a packet.
- `s_dest`  in  FLIT_WIDTH/2  target address, `{x[FLIT_WIDTH/4-1:0], y[FLIT_WIDTH/4-1:0]}`; sampled with the first flit only.
- `tx`  out  1  flit valid toward the router LOCAL `rx`.
- `data_o`  out  FLIT_WIDTH  flit toward the router LOCAL `data_i`.
- `credit_i`  in  1  router LOCAL `credit_o`; the router can accept a flit this cycle.
- `clock_tx`  out  1  equal to `clock`; routed to the router LOCAL `clock_rx`.
- `busy`  out  1  high in any state other than IDLE.
- `pkt_sent`  out  1  one-cycle pulse on the last payload flit transfer.
- `overflow`  out  1  one-cycle pulse when the buffer fills without `s_last`.

## Operation
- Accept: a flit transfers when `s_valid && s_ready`. Transfer: a flit transfers to the router when `tx && credit_i`.
- `s_ready = !reset && (state ∈ {IDLE, FILL, DROP})`. This is combinational from state.
- States: IDLE, FILL, DROP, HEADER, SIZE, PAYLOAD.
- IDLE: on accept, write `s_data` to `buf[0]`, capture `s_dest`, and set `count=1`.
  - If `s_last` is high, go to HEADER; otherwise go to FILL.
- FILL: on accept, write `buf[count]` and increment `count`.
  - If `s_last`, go to HEADER.
  - Else if `count` reaches `MAX_PAYLOAD`, pulse `overflow` and go to DROP.
- DROP: accepted flits are discarded. On accepting the flit with `s_last`, go to HEADER. The packet is sent truncated to `MAX_PAYLOAD` flits.
- HEADER: `tx=1`, `data_o = {zeros, dest}`. On transfer, go to SIZE.
- SIZE: `tx=1`, `data_o = count` zero-extended. On transfer, go to PAYLOAD with `rd=0`.
- PAYLOAD: `tx=1`, `data_o = buf[rd]`.
  - On transfer, increment `rd`.
  - The transfer with `rd == count-1` pulses `pkt_sent` and the state goes to IDLE.
- While `credit_i=0`, `tx` and `data_o` hold stable. No flit is skipped or duplicated.
- Widths:
  - `count` is `$clog2(MAX_PAYLOAD+1)` bits.
  - `rd` is `$clog2(MAX_PAYLOAD)` bits.
  - Payloads of 1 to `MAX_PAYLOAD` flits are legal; a zero-length payload cannot occur.
- Only one packet is buffered at a time. The next packet is accepted only after returning to IDLE.

## Timing
- Reset values:
  - state=IDLE, `tx=0`, `data_o=0`, `busy=0`, `pkt_sent=0`, `overflow=0`, `count=0`, `rd=0`.
  - `s_ready=0` while `reset=1`, and 1 in the first cycle after it is released.
- Reset mid-packet abandons the packet on the next edge: `tx` falls and the buffer is discarded. Router-side recovery is a system-level concern.
- `tx` and `data_o` are registered. The header is presented in the cycle after the `s_last` accept.
- With `credit_i` held high, an N-flit payload takes:
  - N accept cycles, then N+2 transfer cycles;
  - then IDLE (`s_ready=1`) in the cycle after the last transfer.
- `pkt_sent` is asserted in the cycle of the final transfer. `overflow` is asserted in the cycle of the filling accept.

## Structure
- `hermes_pkg` holds:
  - the `e_port` enum (EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4);
  - `flit_t`;
  - address field helpers (x/y extraction and packing);
  - the packetizer state enum.
- Sub-module `packetizer_buffer`: single-port-write, single-port-read register array of `MAX_PAYLOAD` x `FLIT_WIDTH` with asynchronous read.
- The FSM, counters and output registers live in `hermes_packetizer`.

## Test plan
- 3-flit packet, dest `0x0101`, payload A,B,C, `credit_i=1`: expect `data_o` sequence `0x00000101`, 3, A, B, C on consecutive cycles. `pkt_sent` on C.
- Same packet with `credit_i` toggling 1,0,0,1: each flit holds while credit is 0. Exactly 5 transfers in order.
- 18-flit packet, `MAX_PAYLOAD=16`: `overflow` pulses on the 16th accept. Flits 17 and 18 are accepted and dropped. Size flit = 16.
- 1-flit packet with `s_last` on the first flit: header, size=1, payload, then IDLE.
- Back-to-back packets of 2 flits each: the second packet's first accept occurs no earlier than the cycle after the first packet's `pkt_sent`.
- Reset asserted during PAYLOAD: `tx=0` next cycle, `busy=0`, and a fresh packet afterwards is sent correctly.
